// File: rtl/pipeline_muldiv_unit_if.sv
// Operation bus between the EX-stage hazard/issue logic and pipeline_muldiv_unit.
// The master side issues operations; the slave side is the iterative unit.
interface pipeline_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   // Handshake: start is sampled on any posedge where the unit is not in RUN and
   // flush is low; that edge accepts opA/opB/op, which are don't-care afterwards.
   // busy is high for every RUN cycle. done is a one-cycle pulse, and result holds
   // its value from done until the next accepted start. A start raised in the done
   // cycle is accepted immediately. stall is busy, or start while not running.
   logic                   start;
   logic [1:0]             op;
   logic [WIDTH-1:0]       opA;
   logic [WIDTH-1:0]       opB;
   logic                   flush;
   logic                   busy;
   logic                   done;
   logic                   stall;
   logic [2*WIDTH-1:0]     result;
   logic [1:0]             dbgState;

   modport master (
      output start, op, opA, opB, flush,
      input  busy, done, stall, result, dbgState
   );

   modport slave (
      input  start, op, opA, opB, flush,
      output busy, done, stall, result, dbgState
   );
endinterface

// File: rtl/pipeline_muldiv_unit.sv
// Iterative radix-2 multiply unit (shift-add), with restoring divide when the
// MULDIV_DIV_EN macro is defined. One iteration per cycle, WIDTH cycles per operation.
module pipeline_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic                  clk,
   input logic                  reset,
   pipeline_muldiv_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT              stateQ;
   stateT              stateNext;
   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   hiReg;
   logic [WIDTH-1:0]   loReg;
   logic [WIDTH-1:0]   mcand;
   logic               negRes;
   logic [2*WIDTH-1:0] resultReg;

   logic               negA;
   logic               negB;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic               accept;
   logic               step;
   logic               lastStep;

   logic [WIDTH:0]     mulSum;
   logic [WIDTH-1:0]   stepHi;
   logic [WIDTH-1:0]   stepLo;
   logic [2*WIDTH-1:0] prodMag;
   logic [2*WIDTH-1:0] finalRes;

`ifdef MULDIV_DIV_EN
   logic               isDiv;
   logic               negRem;
   logic [WIDTH:0]     remShift;
   logic [WIDTH-1:0]   remSub;
   logic               divGe;
   logic [WIDTH-1:0]   quotFinal;
   logic [WIDTH-1:0]   remFinal;
`else
   logic               unusedOpDiv;
   assign unusedOpDiv = bus.op[1];
`endif

   // Signed operands are reduced to magnitudes; MIN maps to 2**(WIDTH-1), which
   // still fits as an unsigned WIDTH-bit value.
   assign negA = bus.op[0] & bus.opA[WIDTH-1];
   assign negB = bus.op[0] & bus.opB[WIDTH-1];
   assign magA = negA ? -bus.opA : bus.opA;
   assign magB = negB ? -bus.opB : bus.opB;

   assign accept   = (stateQ != RUN) & bus.start & ~bus.flush;
   assign step     = (stateQ == RUN) & ~bus.flush;
   assign lastStep = step & (count == CNT_W'(WIDTH - 1));

   always_comb begin
      stateNext = stateQ;
      case (stateQ)
         IDLE:    if (accept) stateNext = RUN;
         RUN: begin
            if (bus.flush)     stateNext = IDLE;
            else if (lastStep) stateNext = DONE;
         end
         DONE:    stateNext = accept ? RUN : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // hiReg/loReg hold {partial product, multiplier} for a multiply and
   // {partial remainder, dividend/quotient} for a divide.
   always_comb begin
      mulSum = {1'b0, hiReg} + (loReg[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], loReg[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      remShift = {hiReg, loReg[WIDTH-1]};
      divGe    = (remShift >= {1'b0, mcand});
      remSub   = remShift[WIDTH-1:0] - mcand;
      if (isDiv) begin
         stepHi = divGe ? remSub : remShift[WIDTH-1:0];
         stepLo = {loReg[WIDTH-2:0], divGe};
      end
`endif
   end

   always_comb begin
      prodMag  = {stepHi, stepLo};
      finalRes = negRes ? -prodMag : prodMag;
`ifdef MULDIV_DIV_EN
      quotFinal = negRes ? -stepLo : stepLo;
      remFinal  = negRem ? -stepHi : stepHi;
      if (isDiv) finalRes = {remFinal, quotFinal};
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ    <= IDLE;
         count     <= '0;
         hiReg     <= '0;
         loReg     <= '0;
         mcand     <= '0;
         negRes    <= 1'b0;
         resultReg <= '0;
`ifdef MULDIV_DIV_EN
         isDiv     <= 1'b0;
         negRem    <= 1'b0;
`endif
      end else begin
         stateQ <= stateNext;
         if (accept) begin
            count  <= '0;
            hiReg  <= '0;
            mcand  <= magA;
            loReg  <= magB;
            negRes <= negA ^ negB;
`ifdef MULDIV_DIV_EN
            isDiv  <= bus.op[1];
            negRem <= bus.op[1] & negA;
            if (bus.op[1]) begin
               mcand  <= magB;
               loReg  <= magA;
               // Divide by zero leaves the all-ones quotient uncorrected.
               negRes <= (negA ^ negB) & (bus.opB != '0);
            end
`endif
         end else if (step) begin
            count <= count + CNT_W'(1);
            hiReg <= stepHi;
            loReg <= stepLo;
            if (lastStep) resultReg <= finalRes;
         end
      end
   end

   assign bus.busy     = (stateQ == RUN);
   assign bus.done     = (stateQ == DONE);
   assign bus.stall    = (stateQ == RUN) | (bus.start & (stateQ != RUN));
   assign bus.result   = resultReg;
   assign bus.dbgState = stateQ;

endmodule

// File: tb/tb_pipeline_muldiv_unit.sv
// Bench for pipeline_muldiv_unit (WIDTH=32): vector table, corner sequences, and
// randomized operations checked against an arithmetic reference model.
module tb_pipeline_muldiv_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipeline_muldiv_unit_if #(.WIDTH(W)) bus ();

   pipeline_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] expQ[$];

   typedef struct {
      string        name;
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2*W-1:0] expRes;
   } vecT;

   vecT vecs[$];

   function automatic logic [2*W-1:0] refModel(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      longint sa;
      longint sb;
      longint p;
      longint q;
      longint r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`ifdef MULDIV_DIV_EN
      if (op[1]) begin
         if (b == '0) return {a, {W{1'b1}}};
         if (op[0]) begin
            q = sa / sb;
            r = sa % sb;
         end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
         end
         return {r[W-1:0], q[W-1:0]};
      end
`endif
      if (op[0]) p = sa * sb;
      else p = longint'({32'd0, a} * {32'd0, b});
      return p;
   endfunction

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Called at the negedge after the accepting edge; start may still be held.
   task automatic waitDone(input string name);
      int lat = 0;
      int busyCnt = 0;
      logic [2*W-1:0] expv;
      while (bus.done !== 1'b1 && lat < 100) begin
         if (bus.busy === 1'b1) busyCnt++;
         @(negedge clk);
         lat++;
      end
      expv = (expQ.size() > 0) ? expQ.pop_front() : '0;
      if (bus.done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no done after %0d cycles", name, lat);
      end else begin
         check({name, " latency"}, lat, W);
         check({name, " busy cycles"}, busyCnt, W);
         check({name, " result"}, bus.result, expv);
      end
   endtask

   task automatic doOp(input string name, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W-1:0] expv);
      logic [2*W-1:0] held;
      bus.start = 1'b1;
      bus.op    = op;
      bus.opA   = a;
      bus.opB   = b;
      expQ.push_back(expv);
      #1 check({name, " stall on start"}, bus.stall, 1);
      @(negedge clk);
      bus.start = 1'b0;
      bus.opA   = $urandom;
      bus.opB   = $urandom;
      waitDone(name);
      held = bus.result;
      @(negedge clk);
      check({name, " done pulse"}, bus.done, 0);
      check({name, " result hold"}, bus.result, held);
   endtask

   initial begin
      logic [1:0] rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [2*W-1:0] lastRes;
      int doneSeen;

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = 2'b00;
      bus.opA   = '0;
      bus.opB   = '0;
      repeat (3) @(negedge clk);
      check("reset busy", bus.busy, 0);
      check("reset done", bus.done, 0);
      check("reset result", bus.result, 0);
      check("reset stall", bus.stall, 0);
      check("reset state", bus.dbgState, 0);
      reset = 1'b0;
      @(negedge clk);

      vecs.push_back('{"umul max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001});
      vecs.push_back('{"smul -3*5", 2'b01, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1});
      vecs.push_back('{"smul min*min", 2'b01, 32'h80000000, 32'h80000000, 64'h40000000_00000000});
      vecs.push_back('{"smul -1*-1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1});
      vecs.push_back('{"smul max*min", 2'b01, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000});
      vecs.push_back('{"umul zero", 2'b00, 32'd0, 32'h12345678, 64'h0});
`ifdef MULDIV_DIV_EN
      vecs.push_back('{"sdiv -7/2", 2'b11, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD});
      vecs.push_back('{"udiv 100/7", 2'b10, 32'd100, 32'd7, 64'h00000002_0000000E});
      vecs.push_back('{"udiv 5/0", 2'b10, 32'd5, 32'd0, 64'h00000005_FFFFFFFF});
      vecs.push_back('{"sdiv min/-1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000});
      vecs.push_back('{"sdiv -5/0", 2'b11, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF});
      vecs.push_back('{"sdiv 7/-2", 2'b11, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD});
`else
      vecs.push_back('{"op10 as mul 6*7", 2'b10, 32'd6, 32'd7, 64'd42});
      vecs.push_back('{"op11 as smul -6*7", 2'b11, 32'hFFFFFFFA, 32'd7, 64'hFFFFFFFF_FFFFFFD6});
`endif
      foreach (vecs[i]) doOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expRes);

      // Flush in the middle of RUN: unit idles and the previous result survives.
      lastRes = bus.result;
      bus.start = 1'b1; bus.op = 2'b00; bus.opA = 32'd123; bus.opB = 32'd456;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush busy", bus.busy, 0);
      check("flush state", bus.dbgState, 0);
      doneSeen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1) doneSeen++;
         @(negedge clk);
      end
      check("flush no done", doneSeen, 0);
      check("flush result kept", bus.result, lastRes);

      // Flush and start on the same edge: stays idle.
      bus.start = 1'b1; bus.flush = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      check("flush+start busy", bus.busy, 0);
      check("flush+start state", bus.dbgState, 0);
      check("flush+start result", bus.result, lastRes);

      // Back-to-back: start held through RUN with changing operands, reissued on done.
      bus.start = 1'b1; bus.op = 2'b00; bus.opA = 32'd1000; bus.opB = 32'd3000;
      expQ.push_back(64'd3000000);
      @(negedge clk);
      bus.op = 2'b01; bus.opA = 32'hFFFFFFF7; bus.opB = 32'd11;
      expQ.push_back(64'hFFFFFFFF_FFFFFF9D);
      waitDone("b2b first");
      @(negedge clk);
      check("b2b no bubble", bus.busy, 1);
      bus.start = 1'b0;
      bus.opA = $urandom;
      bus.opB = $urandom;
      waitDone("b2b second");
      @(negedge clk);
      check("b2b second done pulse", bus.done, 0);

      // Reset while running, then a normal operation.
      bus.start = 1'b1; bus.op = 2'b01; bus.opA = 32'd77; bus.opB = 32'd99;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrun reset busy", bus.busy, 0);
      check("midrun reset done", bus.done, 0);
      check("midrun reset result", bus.result, 0);
      reset = 1'b0;
      doOp("after reset", 2'b00, 32'd6, 32'd7, 64'd42);

      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = 32'hFFFFFFFF;
            2: rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         doOp($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, refModel(rop, ra, rb));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: bench did not finish");
      $fatal(1, "global timeout");
   end
endmodule
